nios2_mul_result_sequencer: RTL and testbench
=============================================

// Module: nios2_mul_result_sequencer
// PURPOSE
//  Multi-cycle multiply front end. Accepts 32x32 requests on a valid/ready port.
//  Drives an external 16x16 three-partial-product multiply cell (p1=lo*lo, p2=alo*bhi, p3=ahi*blo).
//  Assembles the partials into the low 32-bit product, or the high word for MULX* ops.
//  Returns the result on a valid/ready port. Sits between the E-stage operand mux and the cell.
// PARAMETERS
//  CELL_LATENCY  1  clocks from cell_en-qualified operands to valid cell_p*; legal range 1..4
// PORTS
//  clk        in   1   system clock, all logic rising-edge
//  reset_n    in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept; high only in IDLE
//  req_op     in   2   00 MUL(lo), 01 MULXUU, 10 MULXSU (a signed), 11 MULXSS
//  req_a      in   32  operand a
//  req_b      in   32  operand b
//  rsp_valid  out  1   result present; held until rsp_ready
//  rsp_ready  in   1   consumer accepts result
//  rsp_data   out  32  product word
//  cell_src1  out  32  to cell E_src1
//  cell_src2  out  32  to cell E_src2
//  cell_en    out  1   to cell M_en
//  cell_p1    in   32  cell lo*lo
//  cell_p2    in   32  cell src1[15:0]*src2[31:16]
//  cell_p3    in   32  cell src1[31:16]*src2[15:0]
// BEHAVIOUR
//  Reset (async): state=IDLE; rsp_valid=0, rsp_data=0, cell_en=0, cell_src1/2=0, acc=0.
//  req_ready=1 in IDLE, so it is 1 during reset.
//  States: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, RESP.
//  IDLE: on req_valid&req_ready, latch a, b, op -> ISSUE1.
//  ISSUE1: cell_src1=a, cell_src2=b, cell_en=1 for exactly CELL_LATENCY cycles (down counter) -> CAP1.
//  CAP1: cell_en=0. acc[49:0] = p1 + (p2<<16) + (p3<<16), unsigned, no truncation.
//        op==MUL: rsp_data=acc[31:0] -> RESP. Otherwise -> ISSUE2.
//  ISSUE2: cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1 for CELL_LATENCY cycles -> CAP2.
//  CAP2: hi = acc[49:32] + p1 - (a[31]&op[1] ? b:0) - (b[31]&op==11 ? a:0), mod 2^32.
//        rsp_data=hi -> RESP.
//  RESP: rsp_valid=1; rsp_data stable. On rsp_ready: rsp_valid=0 -> IDLE.
//  req_ready=0 in every state except IDLE; no request is accepted while a response is pending.
//  Latency (accept edge ends cycle T): MUL rsp_valid at cycle T+CELL_LATENCY+2.
//  MULX* rsp_valid at cycle T+2*CELL_LATENCY+3.
//  cell_en is 0 outside ISSUE states; the cell holds its outputs and the block ignores them.
//  Arithmetic: all modulo 2^32 on output; carries from p2+p3 into bit 48 must reach hi.
//  Reset mid-operation: immediate return to IDLE; partial acc and pending response discarded.
//  rsp_ready high while rsp_valid is low has no effect.
// CONFIGURATION
//  NIOS2_MUL_HIGH_EN defined: full op decode, two-pass MULX* as above.
//  Not defined: req_op ignored; every request is MUL.
//    ISSUE2/CAP2 and the sign-correction logic are not built; latency is always T+CELL_LATENCY+2.
// TESTING
//  1. a=b=0xFFFFFFFF -> MUL 0x00000001; MULXUU 0xFFFFFFFE; MULXSU 0xFFFFFFFF; MULXSS 0x00000000.
//  2. a=b=0x80000000 -> MULXUU 0x40000000; MULXSS 0x40000000; MULXSU 0xC0000000; MUL 0x00000000.
//  3. a=b=0x00010000 -> MUL 0x00000000 (wrap); MULXUU 0x00000001; a=0x0000FFFF,b=0x00010001 MUL 0xFFFFFFFF.
//  4. MUL 3*5, rsp_ready low 5 cycles -> rsp_valid=1, rsp_data=0x0000000F stable; req_ready=0 throughout.
//  5. reset_n pulsed in ISSUE2 -> rsp_valid=0, cell_en=0, req_ready=1 immediately; next MUL 7*9 -> 0x0000003F.
//  6. CELL_LATENCY=2, back-to-back reqs -> MUL rsp_valid at T+4, MULXUU at T+7; cell_en high exactly 2 cycles/pass.

Source files
------------

// File: rtl/nios2_mul_result_sequencer.sv
// Multi-cycle 32x32 multiply sequencer driving an external 16x16 three-partial-product cell.
// Optional feature macro NIOS2_MUL_HIGH_EN: builds the second pass for MULXUU/MULXSU/MULXSS.
module nios2_mul_result_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  typedef enum logic [2:0] {IDLE, ISSUE1, CAP1, ISSUE2, CAP2, RESP} state_e;

  localparam logic [2:0] CNT_INIT = 3'(CELL_LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [49:0] acc_q, acc_d;
  logic        cell_en_q, cell_en_d;
  logic [31:0] cell_src1_q, cell_src1_d, cell_src2_q, cell_src2_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [49:0] acc_sum;

  // Full-width sum keeps the p2+p3 carry into bit 48 for the high-word pass.
  function automatic logic [49:0] low_accumulate(input logic [31:0] p1, input logic [31:0] p2,
                                                 input logic [31:0] p3);
    return {18'h0, p1} + {2'b00, p2, 16'h0} + {2'b00, p3, 16'h0};
  endfunction

  assign acc_sum = low_accumulate(cell_p1, cell_p2, cell_p3);

`ifdef NIOS2_MUL_HIGH_EN
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_word;

  // Signed operands are folded in by subtracting the other operand when the sign bit is set.
  function automatic logic [31:0] high_word(input logic [17:0] acc_hi, input logic [31:0] p_hh,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    logic [31:0] corr_a, corr_b;
    corr_a = (a[31] && op[1]) ? b : 32'h0;
    corr_b = (b[31] && op == 2'b11) ? a : 32'h0;
    return {14'h0, acc_hi} + p_hh - corr_a - corr_b;
  endfunction

  assign hi_word = high_word(acc_q[49:32], cell_p1, a_q, b_q, op_q);
`else
  logic unused_sig;
  assign unused_sig = ^{req_op, acc_q[49:32]};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cell_en_d   = cell_en_q;
    cell_src1_d = cell_src1_q;
    cell_src2_d = cell_src2_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef NIOS2_MUL_HIGH_EN
    op_d        = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d         = req_a;
          b_d         = req_b;
`ifdef NIOS2_MUL_HIGH_EN
          op_d        = req_op;
`endif
          cell_src1_d = req_a;
          cell_src2_d = req_b;
          cell_en_d   = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = ISSUE1;
        end
      end
      ISSUE1: begin
        if (cnt_q == 3'd0) begin
          cell_en_d = 1'b0;
          state_d   = CAP1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAP1: begin
        acc_d = acc_sum;
`ifdef NIOS2_MUL_HIGH_EN
        if (op_q == 2'b00) begin
          rsp_data_d  = acc_sum[31:0];
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cell_src1_d = {16'h0, a_q[31:16]};
          cell_src2_d = {16'h0, b_q[31:16]};
          cell_en_d   = 1'b1;
          cnt_d       = CNT_INIT;
          state_d     = ISSUE2;
        end
`else
        rsp_data_d  = acc_sum[31:0];
        rsp_valid_d = 1'b1;
        state_d     = RESP;
`endif
      end
`ifdef NIOS2_MUL_HIGH_EN
      ISSUE2: begin
        if (cnt_q == 3'd0) begin
          cell_en_d = 1'b0;
          state_d   = CAP2;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      CAP2: begin
        rsp_data_d  = hi_word;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      acc_q       <= 50'h0;
      cell_en_q   <= 1'b0;
      cell_src1_q <= 32'h0;
      cell_src2_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
`ifdef NIOS2_MUL_HIGH_EN
      op_q        <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cell_en_q   <= cell_en_d;
      cell_src1_q <= cell_src1_d;
      cell_src2_q <= cell_src2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef NIOS2_MUL_HIGH_EN
      op_q        <= op_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign cell_en   = cell_en_q;
  assign cell_src1 = cell_src1_q;
  assign cell_src2 = cell_src2_q;

endmodule

// File: tb/tb_nios2_mul_result_sequencer.sv
// Directed bench: a latency-1 instance for result/handshake/reset cases, a latency-2 instance for timing.
module tb_nios2_mul_result_sequencer;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req_valid = '0, req_ready, rsp_valid, rsp_ready = '0, cell_en;
  logic [1:0][1:0]   req_op = '0;
  logic [1:0][31:0]  req_a = '0, req_b = '0, rsp_data, cell_src1, cell_src2;
  logic [1:0][31:0]  cell_p1, cell_p2, cell_p3;
  logic [95:0]       c0_out, c1_stage, c1_out;
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  nios2_mul_result_sequencer #(.CELL_LATENCY(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_a(req_a[0]), .req_b(req_b[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .cell_src1(cell_src1[0]),
    .cell_src2(cell_src2[0]), .cell_en(cell_en[0]), .cell_p1(cell_p1[0]),
    .cell_p2(cell_p2[0]), .cell_p3(cell_p3[0]));

  nios2_mul_result_sequencer #(.CELL_LATENCY(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_a(req_a[1]), .req_b(req_b[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .cell_src1(cell_src1[1]),
    .cell_src2(cell_src2[1]), .cell_en(cell_en[1]), .cell_p1(cell_p1[1]),
    .cell_p2(cell_p2[1]), .cell_p3(cell_p3[1]));

  function automatic logic [95:0] cell_products(input logic [31:0] s1, input logic [31:0] s2);
    logic [31:0] lo, p2, p3;
    lo = {16'h0, s1[15:0]} * {16'h0, s2[15:0]};
    p2 = {16'h0, s1[15:0]} * {16'h0, s2[31:16]};
    p3 = {16'h0, s1[31:16]} * {16'h0, s2[15:0]};
    return {p3, p2, lo};
  endfunction

  // Cell models: pipeline advances only while cell_en is high, outputs hold otherwise.
  always @(posedge clk) begin
    if (cell_en[0]) c0_out <= cell_products(cell_src1[0], cell_src2[0]);
    if (cell_en[1]) begin
      c1_stage <= cell_products(cell_src1[1], cell_src2[1]);
      c1_out   <= c1_stage;
    end
  end

  assign cell_p1[0] = c0_out[31:0];
  assign cell_p2[0] = c0_out[63:32];
  assign cell_p3[0] = c0_out[95:64];
  assign cell_p1[1] = c1_out[31:0];
  assign cell_p2[1] = c1_out[63:32];
  assign cell_p3[1] = c1_out[95:64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_high is the result with the high-word ops built; without them every op is MUL.
  task automatic do_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_high, input int hold,
                       input string tag);
    int          lat, cyc, en_cnt, exp_lat, exp_en;
    logic [31:0] exp;
    lat = (sel == 0) ? 1 : 2;
`ifdef NIOS2_MUL_HIGH_EN
    exp     = exp_high;
    exp_lat = (op == 2'b00) ? lat + 2 : 2 * lat + 3;
    exp_en  = (op == 2'b00) ? lat : 2 * lat;
`else
    exp     = a * b;
    exp_lat = lat + 2;
    exp_en  = lat;
`endif
    chk({tag, ":req_ready_idle"}, 32'(req_ready[sel]), 32'd1);
    req_valid[sel] = 1'b1;
    req_op[sel]    = op;
    req_a[sel]     = a;
    req_b[sel]     = b;
    tick();
    req_valid[sel] = 1'b0;
    cyc    = 1;
    en_cnt = 0;
    while (rsp_valid[sel] !== 1'b1 && cyc < 40) begin
      if (cell_en[sel] === 1'b1) en_cnt++;
      tick();
      cyc++;
    end
    chk({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ":cell_en_cycles"}, 32'(en_cnt), 32'(exp_en));
    chk({tag, ":data"}, rsp_data[sel], exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ":hold_valid"}, 32'(rsp_valid[sel]), 32'd1);
      chk({tag, ":hold_data"}, rsp_data[sel], exp);
      chk({tag, ":hold_req_ready"}, 32'(req_ready[sel]), 32'd0);
    end
    rsp_ready[sel] = 1'b1;
    tick();
    rsp_ready[sel] = 1'b0;
    chk({tag, ":valid_drop"}, 32'(rsp_valid[sel]), 32'd0);
    chk({tag, ":back_idle"}, 32'(req_ready[sel]), 32'd1);
  endtask

  initial begin
    #3;
    for (int s = 0; s < 2; s++) begin
      chk("reset:req_ready", 32'(req_ready[s]), 32'd1);
      chk("reset:rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("reset:rsp_data", rsp_data[s], 32'h0);
      chk("reset:cell_en", 32'(cell_en[s]), 32'd0);
      chk("reset:cell_src1", cell_src1[s], 32'h0);
      chk("reset:cell_src2", cell_src2[s], 32'h0);
    end
    tick();
    reset_n = 1'b1;
    tick();

    do_op(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, "ones_mul");
    do_op(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "ones_mulxuu");
    do_op(0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "ones_mulxsu");
    do_op(0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, "ones_mulxss");
    do_op(0, 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 0, "min_mulxuu");
    do_op(0, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 0, "min_mulxss");
    do_op(0, 2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 0, "min_mulxsu");
    do_op(0, 2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 0, "min_mul");
    do_op(0, 2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 0, "wrap_mul");
    do_op(0, 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 0, "carry_mulxuu");
    do_op(0, 2'b00, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 0, "mid_mul");
    do_op(0, 2'b00, 32'd3, 32'd5, 32'h0000000F, 5, "stall_mul");

    // A stray rsp_ready while idle must not create or consume anything.
    rsp_ready[0] = 1'b1;
    tick();
    tick();
    rsp_ready[0] = 1'b0;
    chk("idle_ready:rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("idle_ready:req_ready", 32'(req_ready[0]), 32'd1);

    // Reset three cycles after accept lands in ISSUE2 for a high-word op.
    req_valid[0] = 1'b1;
    req_op[0]    = 2'b01;
    req_a[0]     = 32'h12345678;
    req_b[0]     = 32'h9ABCDEF0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("midreset:rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("midreset:cell_en", 32'(cell_en[0]), 32'd0);
    chk("midreset:req_ready", 32'(req_ready[0]), 32'd1);
    #3;
    reset_n = 1'b1;
    tick();
    do_op(0, 2'b00, 32'd7, 32'd9, 32'h0000003F, 0, "post_reset_mul");

    do_op(1, 2'b00, 32'd3, 32'd5, 32'h0000000F, 0, "lat2_mul");
    do_op(1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, "lat2_mulxuu");
    do_op(1, 2'b11, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 2, "lat2_mulxss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
